// File: rtl/sram_controller.sv
// Two-phase (high half, then low half) 32-bit access bridge onto a 16-bit external SRAM.
// Optional macro SRAM_POSTED_WRITE_EN: writes complete to the pipeline at once and drain in the background.
module sram_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

    localparam logic [2:0] LAST_COUNT = 3'(WAIT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [2:0]  count;
    logic        phase_last;
    logic        request;
    logic [31:0] offset;
    logic [16:0] word;
    logic [16:0] word_latch;
    logic [15:0] data_lo_latch;
    logic        write_latch;
    logic        unused_offset_bits;

    assign request            = rd_en | wr_en;
    assign phase_last         = (count == LAST_COUNT);
    assign offset             = address - 32'd1024;
    assign word               = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = ~request;
`ifdef SRAM_POSTED_WRITE_EN
                if (wr_en) ready = 1'b1;
`endif
                if (request) state_next = HI;
            end
            HI: begin
                if (phase_last) state_next = LO;
            end
            LO: begin
                if (phase_last) begin
`ifdef SRAM_POSTED_WRITE_EN
                    // A posted write was already acknowledged, so it has no DONE cycle.
                    state_next = write_latch ? IDLE : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 3'd0;
        end else if ((state == HI) || (state == LO)) begin
            count <= phase_last ? 3'd0 : count + 3'd1;
        end else begin
            count <= 3'd0;
        end
    end

    // SRAM pins are registered, so each phase's values are loaded on the edge entering it.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data     <= 32'd0;
            sram_addr     <= 18'd0;
            sram_dq_out   <= 16'd0;
            sram_dq_oe    <= 1'b0;
            sram_we_n     <= 1'b1;
            word_latch    <= 17'd0;
            data_lo_latch <= 16'd0;
            write_latch   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        word_latch    <= word;
                        data_lo_latch <= write_data[15:0];
                        write_latch   <= wr_en;
                        sram_addr     <= {word, 1'b0};
                        sram_dq_out   <= write_data[31:16];
                        sram_dq_oe    <= wr_en;
                        sram_we_n     <= ~wr_en;
                    end
                end
                HI: begin
                    if (phase_last) begin
                        sram_addr   <= {word_latch, 1'b1};
                        sram_dq_out <= data_lo_latch;
                        if (!write_latch) read_data[31:16] <= sram_dq_in;
                    end
                end
                LO: begin
                    if (phase_last) begin
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!write_latch) read_data[15:0] <= sram_dq_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller (WAIT_CYCLES=2) with a behavioural 16-bit SRAM.
// Build with SRAM_POSTED_WRITE_EN defined to exercise the posted-write scenario instead.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:63];

    logic        tr_ready [0:15];
    logic        tr_we_n  [0:15];
    logic        tr_oe    [0:15];
    logic [17:0] tr_addr  [0:15];
    logic [15:0] tr_dq    [0:15];
    logic [31:0] tr_rd    [0:15];

    sram_controller #(.WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM that latches a write on each rising edge with the strobe low.
    assign sram_dq_in = mem[sram_addr[5:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic record(input int c);
        tr_ready[c] = ready;
        tr_we_n[c]  = sram_we_n;
        tr_oe[c]    = sram_dq_oe;
        tr_addr[c]  = sram_addr;
        tr_dq[c]    = sram_dq_out;
        tr_rd[c]    = read_data;
    endtask

    // Presents a request at a falling edge and traces n cycles, leaving the request applied.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input int n);
        @(negedge clk);
        rd_en = rd;
        wr_en = wr;
        address = addr;
        write_data = data;
        #1 record(0);
        for (int c = 1; c < n; c++) begin
            @(negedge clk);
            #1 record(c);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rd_en = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = 32'd0;
        write_data = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_read_data", read_data, 32'd0);
        checkOutput("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        checkOutput("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        checkOutput("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        checkOutput("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        checkOutput("rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        idleCycles(1);

`ifdef SRAM_POSTED_WRITE_EN
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1);
        checkOutput("pw_write_ready_c0", {31'd0, tr_ready[0]}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0, 14);
        for (int c = 0; c < 14; c++)
            checkOutput($sformatf("pw_read_ready_c%0d", c + 1), {31'd0, tr_ready[c]}, (c == 13) ? 32'd1 : 32'd0);
        checkOutput("pw_drain_we_n_c1", {31'd0, tr_we_n[0]}, 32'd0);
        checkOutput("pw_drain_addr_c4", {14'd0, tr_addr[3]}, 32'd3);
        checkOutput("pw_read_data_c14", tr_rd[13], 32'hDEADBEEF);
        idleCycles(2);
        checkOutput("pw_mem2", {16'd0, mem[2]}, 32'h0000DEAD);
        checkOutput("pw_mem3", {16'd0, mem[3]}, 32'h0000BEEF);
`else
        // Write 0xDEADBEEF to 1028: halfwords 2 and 3, three strobe cycles each.
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 8);
        idleCycles(1);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("s1_ready_c%0d", c), {31'd0, tr_ready[c]}, (c == 7) ? 32'd1 : 32'd0);
            checkOutput($sformatf("s1_we_n_c%0d", c), {31'd0, tr_we_n[c]}, (c >= 1 && c <= 6) ? 32'd0 : 32'd1);
        end
        for (int c = 1; c <= 6; c++) begin
            checkOutput($sformatf("s1_addr_c%0d", c), {14'd0, tr_addr[c]}, (c <= 3) ? 32'd2 : 32'd3);
            checkOutput($sformatf("s1_dq_c%0d", c), {16'd0, tr_dq[c]}, (c <= 3) ? 32'h0000DEAD : 32'h0000BEEF);
            checkOutput($sformatf("s1_oe_c%0d", c), {31'd0, tr_oe[c]}, 32'd1);
        end
        checkOutput("s1_mem2", {16'd0, mem[2]}, 32'h0000DEAD);
        checkOutput("s1_mem3", {16'd0, mem[3]}, 32'h0000BEEF);

        // Read 1028 back, then the unaligned alias 1030.
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0, 8);
        idleCycles(1);
        checkOutput("s2_ready_c6", {31'd0, tr_ready[6]}, 32'd0);
        checkOutput("s2_ready_c7", {31'd0, tr_ready[7]}, 32'd1);
        checkOutput("s2_rd_hi_only_c6", tr_rd[6], 32'hDEAD0000);
        checkOutput("s2_rd_c7", tr_rd[7], 32'hDEADBEEF);
        checkOutput("s2_we_n_c2", {31'd0, tr_we_n[2]}, 32'd1);
        checkOutput("s2_oe_c2", {31'd0, tr_oe[2]}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd1030, 32'd0, 8);
        idleCycles(1);
        checkOutput("s2_alias_addr_c1", {14'd0, tr_addr[1]}, 32'd2);
        checkOutput("s2_alias_addr_c5", {14'd0, tr_addr[5]}, 32'd3);
        checkOutput("s2_alias_rd_c7", tr_rd[7], 32'hDEADBEEF);

        // Read and write together resolve to a write.
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'h12345678, 8);
        idleCycles(1);
        checkOutput("s3_addr_c1", {14'd0, tr_addr[1]}, 32'd4);
        checkOutput("s3_dq_c1", {16'd0, tr_dq[1]}, 32'h00001234);
        checkOutput("s3_we_n_c1", {31'd0, tr_we_n[1]}, 32'd0);
        checkOutput("s3_addr_c4", {14'd0, tr_addr[4]}, 32'd5);
        checkOutput("s3_dq_c4", {16'd0, tr_dq[4]}, 32'h00005678);
        checkOutput("s3_rd_unchanged_c7", tr_rd[7], 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, 8);
        idleCycles(1);
        checkOutput("s3_read_back", tr_rd[7], 32'h12345678);

        // Reset during the second HI cycle of a write to 1028.
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("s4_we_n", {31'd0, sram_we_n}, 32'd1);
        checkOutput("s4_oe", {31'd0, sram_dq_oe}, 32'd0);
        checkOutput("s4_read_data_cleared", read_data, 32'd0);
        checkOutput("s4_ready_idle_req", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        #1;
        checkOutput("s4_ready_idle", {31'd0, ready}, 32'd1);
        checkOutput("s4_mem3_untouched", {16'd0, mem[3]}, 32'h0000BEEF);
        checkOutput("s4_mem2_written", {16'd0, mem[2]}, 32'h0000CAFE);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0, 8);
        idleCycles(1);
        checkOutput("s4_after_ready_c7", {31'd0, tr_ready[7]}, 32'd1);
        checkOutput("s4_after_rd_c6", tr_rd[6], 32'hCAFE0000);
        checkOutput("s4_after_rd_c7", tr_rd[7], 32'hCAFEBEEF);

        // Back-to-back read of 1032 then write to 1036 with no idle cycle between.
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, 8);
        checkOutput("s5_read_ready_c7", {31'd0, tr_ready[7]}, 32'd1);
        checkOutput("s5_read_rd_c7", tr_rd[7], 32'h12345678);
        applyStimulus(1'b0, 1'b1, 32'd1036, 32'hA5A55A5A, 8);
        idleCycles(1);
        checkOutput("s5_write_ready_c8", {31'd0, tr_ready[0]}, 32'd0);
        checkOutput("s5_write_we_n_c9", {31'd0, tr_we_n[1]}, 32'd0);
        checkOutput("s5_write_addr_c9", {14'd0, tr_addr[1]}, 32'd6);
        checkOutput("s5_write_ready_c14", {31'd0, tr_ready[6]}, 32'd0);
        checkOutput("s5_write_ready_c15", {31'd0, tr_ready[7]}, 32'd1);
        checkOutput("s5_rd_held", tr_rd[7], 32'h12345678);
        checkOutput("s5_mem6", {16'd0, mem[6]}, 32'h0000A5A5);
        checkOutput("s5_mem7", {16'd0, mem[7]}, 32'h00005A5A);

        // Base address maps to halfword 0.
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0BADCAFE, 8);
        idleCycles(1);
        checkOutput("base_addr_c1", {14'd0, tr_addr[1]}, 32'd0);
        checkOutput("base_addr_c4", {14'd0, tr_addr[4]}, 32'd1);
        checkOutput("base_mem0", {16'd0, mem[0]}, 32'h00000BAD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
